pipelined_adder_32bit: RTL and testbench

Registered, handshaked 32-bit adder built from chained 4-bit prefix slices, with the carry chain split across pipeline stages so each stage resolves STAGE_W bits per cycle. It sits between the operand-issue logic and the result consumer in the arithmetic datapath. It accepts one operand pair per cycle and returns results in order, with full backpressure support.

---
 rtl/adder_pkg.sv | 20 ++
 rtl/pg_slice_4bit.sv | 24 ++
 rtl/pipelined_adder_32bit.sv | 119 +++++++++++
 tb/tb_pipelined_adder_32bit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared defaults, stage-count helper and the per-stage register layout for
// the pipelined adder.
package adder_pkg;
  localparam int ADDER_DATA_W  = 32;
  localparam int ADDER_STAGE_W = 8;

  function automatic int nstg(input int dw, input int sw);
    return dw / sw;
  endfunction

  // Sum bits below the stage boundary are final; a/b carry the operand bits
  // that later stages still have to add.
  typedef struct packed {
    logic                    vld;
    logic [ADDER_DATA_W-1:0] sum;
    logic                    cy;
    logic [ADDER_DATA_W-1:0] a;
    logic [ADDER_DATA_W-1:0] b;
  } stg_t;
endpackage

// File: rtl/pg_slice_4bit.sv
// Combinational 4-bit generate/propagate slice with lookahead carries.
module pg_slice_4bit (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_ci,
  output logic [3:0] o_s,
  output logic       o_co
);
  logic [3:0] w_g, w_p;
  logic [4:0] w_c;

  assign w_g    = i_a & i_b;
  assign w_p    = i_a ^ i_b;
  assign w_c[0] = i_ci;
  assign w_c[1] = w_g[0] | (w_p[0] & i_ci);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_ci);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_ci);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_ci);
  assign o_s    = w_p ^ w_c[3:0];
  assign o_co   = w_c[4];
endmodule

// File: rtl/pipelined_adder_32bit.sv
// Handshaked adder resolving STAGE_W bits per pipeline stage with skewed operands.
// Define ADDER_OVF_FLAG_EN to add the registered signed-overflow output ovf.
module pipelined_adder_32bit
  import adder_pkg::*;
#(
  parameter int DATA_W  = ADDER_DATA_W,
  parameter int STAGE_W = ADDER_STAGE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] sum,
  output logic              cout
`ifdef ADDER_OVF_FLAG_EN
  ,
  output logic              ovf
`endif
);
  localparam int NSTG = nstg(DATA_W, STAGE_W);
  localparam int NSL  = STAGE_W / 4;
  localparam int LST  = NSTG - 1;

  stg_t              r_stg  [NSTG];
  logic [NSTG-1:0]   w_adv;
  logic [NSTG-1:0]   w_pv;
  logic [NSTG-1:0]   w_pc;
  logic [NSTG-1:0]   w_co;
  logic [DATA_W-1:0] w_pa   [NSTG];
  logic [DATA_W-1:0] w_pb   [NSTG];
  logic [DATA_W-1:0] w_psum [NSTG];
  logic [DATA_W-1:0] w_snew;

  function automatic logic [DATA_W-1:0] f_smask(input int s);
    f_smask = '0;
    f_smask[s*STAGE_W +: STAGE_W] = '1;
  endfunction

  // Advance chain walks back from the output so in_ready sees out_ready.
  always_comb begin
    logic l_nxt;
    l_nxt = out_ready;
    w_adv = '0;
    for (int s = NSTG - 1; s >= 0; s--) begin
      w_adv[s] = !r_stg[s].vld || l_nxt;
      l_nxt    = w_adv[s];
    end
  end

  for (genvar s = 0; s < NSTG; s++) begin : g_stg
    logic [NSL:0] w_c;

    if (s == 0) begin : g_src_in
      assign w_pv[s]   = in_valid;
      assign w_pa[s]   = a;
      assign w_pb[s]   = b;
      assign w_psum[s] = '0;
      assign w_pc[s]   = cin;
    end else begin : g_src_reg
      assign w_pv[s]   = r_stg[s-1].vld;
      assign w_pa[s]   = r_stg[s-1].a;
      assign w_pb[s]   = r_stg[s-1].b;
      assign w_psum[s] = r_stg[s-1].sum;
      assign w_pc[s]   = r_stg[s-1].cy;
    end

    assign w_c[0] = w_pc[s];
    for (genvar k = 0; k < NSL; k++) begin : g_sl
      pg_slice_4bit u_sl (
        .i_a  (w_pa[s][s*STAGE_W + 4*k +: 4]),
        .i_b  (w_pb[s][s*STAGE_W + 4*k +: 4]),
        .i_ci (w_c[k]),
        .o_s  (w_snew[s*STAGE_W + 4*k +: 4]),
        .o_co (w_c[k+1])
      );
    end
    assign w_co[s] = w_c[NSL];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NSTG; s++) r_stg[s] <= '0;
    end else begin
      for (int s = 0; s < NSTG; s++) begin
        if (w_adv[s]) begin
          r_stg[s].vld <= w_pv[s];
          // Data only moves with a real operand so a stalled-empty output stays quiet.
          if (w_pv[s]) begin
            r_stg[s].a   <= w_pa[s];
            r_stg[s].b   <= w_pb[s];
            r_stg[s].cy  <= w_co[s];
            r_stg[s].sum <= (w_psum[s] & ~f_smask(s)) | (w_snew & f_smask(s));
          end
        end
      end
    end
  end

`ifdef ADDER_OVF_FLAG_EN
  logic r_ovf;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ovf <= 1'b0;
    else if (w_adv[LST] && w_pv[LST])
      r_ovf <= (w_pa[LST][DATA_W-1] == w_pb[LST][DATA_W-1]) &&
               (w_snew[DATA_W-1] != w_pa[LST][DATA_W-1]);
  end
  assign ovf = r_ovf;
`endif

  assign in_ready  = w_adv[0];
  assign out_valid = r_stg[LST].vld;
  assign sum       = r_stg[LST].sum;
  assign cout      = r_stg[LST].cy;
endmodule

// File: tb/tb_pipelined_adder_32bit.sv
// Directed and scoreboarded random checks for pipelined_adder_32bit.
module tb_pipelined_adder_32bit;
  logic        clk, rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, sum;
  logic        cin, cout;
`ifdef ADDER_OVF_FLAG_EN
  logic        ovf;
`endif

  int total = 0;
  int bad   = 0;
  int n_in  = 0;
  int n_out = 0;
  bit sb_en = 0;
  logic [33:0] sb[$];
  logic [33:0] sb_exp;

  pipelined_adder_32bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef ADDER_OVF_FLAG_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: {ovf, cout, sum}
  function automatic logic [33:0] model(input logic [31:0] ma, input logic [31:0] mb, input logic mc);
    logic [32:0] full;
    logic        o;
    full = {1'b0, ma} + {1'b0, mb} + {32'd0, mc};
    o    = (ma[31] == mb[31]) && (full[31] != ma[31]);
    return {o, full};
  endfunction

  always @(negedge clk) begin
    if (sb_en && rst_n) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("sb_extra", 1, 0);
        else begin
          sb_exp = sb.pop_front();
          chk("sb_sum", sum, sb_exp[31:0]);
          chk("sb_cout", cout, sb_exp[32]);
`ifdef ADDER_OVF_FLAG_EN
          chk("sb_ovf", ovf, sb_exp[33]);
`endif
          n_out++;
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(a, b, cin));
        n_in++;
      end
    end
  end

  // One pair through an empty pipe; leaves the result presented.
  task automatic single(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                        input logic tc, input logic [31:0] es, input logic ec);
    out_ready = 1; in_valid = 1; a = ta; b = tb; cin = tc;
    chk({tag, "_rdy"}, in_ready, 1);
    tick;
    in_valid = 0;
    tick; tick;
    chk({tag, "_early"}, out_valid, 0);
    tick;
    chk({tag, "_vld"}, out_valid, 1);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
  endtask

  logic [31:0] da[4] = '{32'd1, 32'd3, 32'h8000_0000, 32'd0};
  logic [31:0] db[4] = '{32'd2, 32'd4, 32'h8000_0000, 32'd0};
  logic        dc[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [31:0] es[4] = '{32'd3, 32'd7, 32'd0, 32'd1};
  logic        ec[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic        eo[4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    int seen;
    rst_n = 0; in_valid = 0; out_ready = 0; a = 0; b = 0; cin = 0;
    #3;
    chk("rst_vld_in", out_valid, 0);
    tick; tick;
    rst_n = 1;
    #1;
    chk("rst_rdy", in_ready, 1);
    chk("rst_vld", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
`ifdef ADDER_OVF_FLAG_EN
    chk("rst_ovf", ovf, 0);
`endif

    single("wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0, 1'b1);
`ifdef ADDER_OVF_FLAG_EN
    chk("wrap_ovf", ovf, 0);
`endif
    tick;
    chk("wrap_done", out_valid, 0);

    // Back-to-back stream
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; a = da[i]; b = db[i]; cin = dc[i];
      chk("b2b_rdy", in_ready, 1);
      tick;
    end
    in_valid = 0;
    for (int i = 0; i < 4; i++) begin
      chk("b2b_vld", out_valid, 1);
      chk("b2b_sum", sum, es[i]);
      chk("b2b_cout", cout, ec[i]);
`ifdef ADDER_OVF_FLAG_EN
      chk("b2b_ovf", ovf, eo[i]);
`endif
      tick;
    end
    chk("b2b_done", out_valid, 0);

`ifdef ADDER_OVF_FLAG_EN
    single("povf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0);
    chk("povf_ovf", ovf, 1);
    tick;
`endif

    // Backpressure: fill, hold, drain
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; a = i + 1; b = 32'h100; cin = 0;
      chk("fill_rdy", in_ready, 1);
      tick;
    end
    a = 5;
    #1;
    chk("full_rdy", in_ready, 0);
    chk("full_vld", out_valid, 1);
    chk("full_sum", sum, 32'h101);
    repeat (3) begin
      tick;
      chk("hold_sum", sum, 32'h101);
      chk("hold_vld", out_valid, 1);
      chk("hold_rdy", in_ready, 0);
    end
    out_ready = 1;
    #1;
    chk("drain_rdy", in_ready, 1);
    for (int k = 0; k < 5; k++) begin
      chk("drain_vld", out_valid, 1);
      chk("drain_sum", sum, k + 1 + 32'h100);
      tick;
      in_valid = 0;
    end
    chk("drain_empty", out_valid, 0);

    // Random traffic against the reference model
    sb_en = 1;
    repeat (10000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      b         = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      cin       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      tick;
    end
    in_valid = 0; out_ready = 1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick;
    chk("sb_drain", sb.size(), 0);
    chk("sb_count", n_out, n_in);
    sb_en = 0;

    // Reset with three operations in flight
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; a = 32'h1000 + i; b = 32'h1; cin = 0;
      tick;
    end
    in_valid = 0;
    tick;
    chk("pre_rst_vld", out_valid, 1);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_vld", out_valid, 0);
    chk("mid_rst_sum", sum, 0);
    tick;
    rst_n = 1;
    out_ready = 1;
    #1;
    chk("post_rst_rdy", in_ready, 1);
    seen = 0;
    repeat (8) begin
      tick;
      if (out_valid) seen++;
    end
    chk("stale", seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
